w_mem_loader: RTL and testbench
===============================

Name: w_mem_loader

Overview:
- Write-side companion to the per-layer weight memories (W_Mem_<layer>_<neuron> family).
- Accepts a beat-per-word weight stream with a valid/ready/last handshake and issues sequential wen/wadd/win writes into one weight memory, starting at address 0.
- Sits between the host/config interface and a weight memory so weights can be reloaded at run time instead of being hard-coded.
- Reports completion, a 16-bit wrapping checksum of the loaded words, and a load error code.

Parameters:
- numWeight, 30, number of words in the target weight memory.
- addressWidth, $clog2(numWeight), width of wadd.
- dataWidth, 16, weight word width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- cfg_count  input  addressWidth+1  number of words to load; legal range 1..numWeight.
- s_valid  input  1  stream word valid.
- s_data  input  dataWidth  stream weight word.
- s_last  input  1  marks the final word of the stream.
- s_ready  output  1  loader can accept a word.
- wen  output  1  memory write enable.
- wadd  output  addressWidth  memory write address.
- win  output  dataWidth  memory write data.
- busy  output  1  high while not IDLE.
- done  output  1  one-cycle pulse at end of load (success or error).
- err_code  output  2  0=OK, 1=BAD_CFG, 2=EARLY_LAST, 3=MISSING_LAST.
- checksum  output  dataWidth  mod-2^dataWidth sum of accepted words.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - State: IDLE.
  - Outputs: s_ready=0, wen=0, wadd=0, win=0, busy=0, done=0, err_code=0, checksum=0.
  - Internal: index=0, count=0.
- States: IDLE, LOAD, DONE.
- IDLE:
  - s_ready=0, busy=0.
  - start=1 with cfg_count in 1..numWeight: latch count, index=0, checksum=0, err_code=0, go to LOAD.
  - start=1 with cfg_count=0 or >numWeight: err_code=1, go to DONE. No write is issued.
- LOAD:
  - s_ready=1 and busy=1, both Moore outputs of the state.
  - A beat is accepted on s_valid && s_ready.
  - Write timing: the accepted beat is registered. On the next cycle wen=1, wadd=index, win=s_data. Fixed 1-cycle latency from accept to write.
  - Per accepted beat: checksum += s_data (wrapping); index increments.
  - Accepted beat with index==count-1: with s_last=1, err_code stays 0; with s_last=0, err_code=3. Either way go to DONE. s_ready drops in the cycle after acceptance.
  - Accepted beat with s_last=1 and index<count-1: the word is still written; err_code=2; go to DONE.
  - s_valid low: no write, nothing changes. Stalls of any length are allowed.
- DONE:
  - Lasts exactly 1 cycle: done=1, busy=1, s_ready=0, then IDLE.
  - The final memory write (wen=1) coincides with the DONE cycle.
- err_code and checksum hold until the next accepted start.
- wen is high for exactly one cycle per accepted beat and never otherwise.
- wadd is never ≥ count, so there is no address wrap.
- start in LOAD/DONE is ignored.
- Stream beats offered in IDLE/DONE are not accepted (s_ready=0).
- rst mid-load:
  - Next-cycle outputs return to reset values; a pending registered write is dropped.
  - Memory keeps any words already written; no rollback.

Decomposition:
- Package fnn_loader_pkg holds:
  - Enum for state (IDLE, LOAD, DONE).
  - Enum for err_code (ERR_OK, ERR_CFG, ERR_EARLY_LAST, ERR_MISSING_LAST).
  - Localparam for the checksum width.
- No sub-module. Single module: FSM, index counter, write register stage, checksum accumulator.

Test Plan:
- Full load, numWeight=30:
  - Stimulus: start with cfg_count=30, stream words 0x0100+i back-to-back, s_last on i=29.
  - Response: 30 writes wadd=0..29, win=0x0100+i, each 1 cycle after accept; done pulse; err_code=0; checksum=0x1E00+435=0x1FB3.
- Stalled stream:
  - Stimulus: cfg_count=4, words 0xFFFF,0x0001,0x8000,0x8000, s_valid low 3 cycles between beats.
  - Response: 4 writes only, wen never high during gaps; checksum=0x0000; err_code=0.
- Early last:
  - Stimulus: cfg_count=5, s_last on the 3rd word.
  - Response: 3 writes (wadd 0..2); done pulse; err_code=2; s_ready low afterwards.
- Missing last / bad config:
  - Stimulus A: cfg_count=2, s_last never asserted. Response: 2 writes, err_code=3.
  - Stimulus B: cfg_count=0. Response: done within 2 cycles, err_code=1, no wen.
  - Stimulus C: cfg_count=31. Response: same as B.
- Reset mid-load and ignored start:
  - Stimulus: cfg_count=10, assert rst after 4 accepted beats, with a start pulse during LOAD.
  - Response: extra start has no effect; the cycle after rst has wen=0, busy=0, s_ready=0, checksum=0.
  - Response, follow-up: a new start with cfg_count=1 loads wadd=0 normally.

Source files
------------

// File: rtl/fnn_loader_pkg.sv
// Shared types for the weight-memory loader: FSM states, load error codes
// and the checksum width.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package fnn_loader_pkg;

    // Loader control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // Result of a load, reported on err_code.
    typedef enum logic [1:0] {
        ERR_OK           = 2'd0,  // stream length matched cfg_count
        ERR_CFG          = 2'd1,  // cfg_count was 0 or above the memory depth
        ERR_EARLY_LAST   = 2'd2,  // s_last arrived before cfg_count words
        ERR_MISSING_LAST = 2'd3   // cfg_count words arrived without s_last
    } err_t;

    // Width of the running word checksum (matches the weight word width).
    localparam int CHECKSUM_W = 16;

endpackage

// File: rtl/w_mem_loader.sv
// Streams weight words into one weight memory as sequential writes from address 0.
// Latency: one cycle from an accepted beat to its wen/wadd/win write.
// Backpressure: s_ready is high for the whole LOAD state; upstream stalls freely via s_valid.
//
// Ports:
//   clk, rst            - system clock, synchronous active-high reset
//   start, cfg_count    - load request and number of words to load (1..numWeight)
//   s_valid/s_data/s_last/s_ready - weight word stream, one word per beat
//   wen, wadd, win      - write port towards the weight memory
//   busy, done          - busy while not IDLE; done pulses for the single DONE cycle
//   err_code, checksum  - load result and wrapping sum of accepted words, held until next start
module w_mem_loader
    import fnn_loader_pkg::*;
#(
    parameter int numWeight    = 30,
    parameter int addressWidth = $clog2(numWeight),
    parameter int dataWidth    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [addressWidth:0]     cfg_count,
    input  logic                      s_valid,
    input  logic [dataWidth-1:0]      s_data,
    input  logic                      s_last,
    output logic                      s_ready,
    output logic                      wen,
    output logic [addressWidth-1:0]   wadd,
    output logic [dataWidth-1:0]      win,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                err_code,
    output logic [dataWidth-1:0]      checksum
);

    localparam logic [addressWidth:0] MAX_CNT = (addressWidth + 1)'(numWeight);
    localparam logic [addressWidth:0] ONE     = (addressWidth + 1)'(1);

    state_t                  state;
    state_t                  state_nxt;
    logic [addressWidth:0]   count;
    logic [addressWidth:0]   index;
    err_t                    err_q;
    logic                    cfg_ok;
    logic                    accept;
    logic                    at_final;

    // Next-state logic and Moore outputs.
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        cfg_ok    = (cfg_count != '0) && (cfg_count <= MAX_CNT);
        accept    = 1'b0;
        at_final  = (index == (count - ONE));

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = cfg_ok ? LOAD : DONE;
                end
            end
            LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                accept  = s_valid;
                // Either the expected last word or an early s_last ends the load.
                if (s_valid && (s_last || at_final)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: write register stage, index counter, checksum and error code.
    always_ff @(posedge clk) begin
        if (rst) begin
            // A write registered in the reset cycle is dropped here.
            wen      <= 1'b0;
            wadd     <= '0;
            win      <= '0;
            index    <= '0;
            count    <= '0;
            checksum <= '0;
            err_q    <= ERR_OK;
        end else begin
            wen <= accept;

            if (state == IDLE && start) begin
                if (cfg_ok) begin
                    count    <= cfg_count;
                    index    <= '0;
                    checksum <= '0;
                    err_q    <= ERR_OK;
                end else begin
                    err_q <= ERR_CFG;
                end
            end

            if (accept) begin
                // index never exceeds count-1 while accepting, so the
                // low bits always form a legal address.
                wadd     <= index[addressWidth-1:0];
                win      <= s_data;
                index    <= index + ONE;
                checksum <= checksum + s_data;
                if (at_final) begin
                    err_q <= s_last ? ERR_OK : ERR_MISSING_LAST;
                end else if (s_last) begin
                    err_q <= ERR_EARLY_LAST;
                end
            end
        end
    end

    assign err_code = err_q;

endmodule

// File: tb/tb_w_mem_loader.sv
// Directed self-checking bench for w_mem_loader.
// Inputs change and outputs are sampled on the falling clock edge.
// Every write seen on wen is counted by a small monitor.
module tb_w_mem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  cfg_count;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_last;
    logic        s_ready;
    logic        wen;
    logic [4:0]  wadd;
    logic [15:0] win;
    logic        busy;
    logic        done;
    logic [1:0]  err_code;
    logic [15:0] checksum;

    int pass_cnt = 0;
    int total    = 0;
    int wr_cnt   = 0;
    int base;

    w_mem_loader #(
        .numWeight    (30),
        .addressWidth (5),
        .dataWidth    (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_count (cfg_count),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .wen       (wen),
        .wadd      (wadd),
        .win       (win),
        .busy      (busy),
        .done      (done),
        .err_code  (err_code),
        .checksum  (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: counts every cycle with wen high.
    always @(posedge clk) begin
        if (wen === 1'b1) wr_cnt <= wr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic do_start(input logic [5:0] n);
        start     = 1'b1;
        cfg_count = n;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Offer one beat at a falling edge, then check its write one cycle later.
    task automatic drive(input logic [15:0] d, input logic last,
                         input logic [4:0] exp_addr, input string tag);
        chk({tag, "_rdy"}, 32'(s_ready), 32'd1);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(negedge clk);
        chk({tag, "_wen"}, 32'(wen), 32'd1);
        chk({tag, "_wadd"}, 32'(wadd), 32'(exp_addr));
        chk({tag, "_win"}, 32'(win), 32'(d));
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 16'h0000;
    endtask

    logic [15:0] stall_words [4];

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        cfg_count = 6'd0;
        s_valid   = 1'b0;
        s_data    = 16'h0000;
        s_last    = 1'b0;
        stall_words[0] = 16'hFFFF;
        stall_words[1] = 16'h0001;
        stall_words[2] = 16'h8000;
        stall_words[3] = 16'h8000;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_wen", 32'(wen), 32'd0);
        chk("rst_wadd", 32'(wadd), 32'd0);
        chk("rst_win", 32'(win), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err_code), 32'd0);
        chk("rst_csum", 32'(checksum), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full load of 30 words, back-to-back
        base = wr_cnt;
        do_start(6'd30);
        chk("full_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 30; i++) begin
            drive(16'(16'h0100 + i), (i == 29), 5'(i), $sformatf("full%0d", i));
        end
        chk("full_done", 32'(done), 32'd1);
        chk("full_err", 32'(err_code), 32'd0);
        chk("full_csum", 32'(checksum), 32'h1FB3);
        chk("full_rdy_off", 32'(s_ready), 32'd0);
        chk("full_busy_done", 32'(busy), 32'd1);
        @(negedge clk);
        chk("full_done_pulse", 32'(done), 32'd0);
        chk("full_idle_busy", 32'(busy), 32'd0);
        chk("full_idle_wen", 32'(wen), 32'd0);
        chk("full_wr_cnt", 32'(wr_cnt - base), 32'd30);

        // Stalled stream: 3 idle cycles between beats, checksum wraps to 0
        base = wr_cnt;
        do_start(6'd4);
        for (int i = 0; i < 4; i++) begin
            drive(stall_words[i], (i == 3), 5'(i), $sformatf("stall%0d", i));
            if (i < 3) begin
                for (int g = 0; g < 3; g++) begin
                    @(negedge clk);
                    chk($sformatf("stall_gap%0d_%0d", i, g), 32'(wen), 32'd0);
                end
            end
        end
        chk("stall_done", 32'(done), 32'd1);
        chk("stall_csum", 32'(checksum), 32'h0000);
        chk("stall_err", 32'(err_code), 32'd0);
        @(negedge clk);
        chk("stall_wr_cnt", 32'(wr_cnt - base), 32'd4);

        // Early last on the 3rd of 5 words
        base = wr_cnt;
        do_start(6'd5);
        drive(16'h00A0, 1'b0, 5'd0, "early0");
        drive(16'h00A1, 1'b0, 5'd1, "early1");
        drive(16'h00A2, 1'b1, 5'd2, "early2");
        chk("early_done", 32'(done), 32'd1);
        chk("early_err", 32'(err_code), 32'd2);
        chk("early_rdy", 32'(s_ready), 32'd0);
        // A beat offered in DONE/IDLE must not be accepted
        s_valid = 1'b1;
        s_data  = 16'hBEEF;
        @(negedge clk);
        chk("early_idle_rdy", 32'(s_ready), 32'd0);
        chk("early_idle_wen", 32'(wen), 32'd0);
        chk("early_idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("early_idle_wen2", 32'(wen), 32'd0);
        s_valid = 1'b0;
        s_data  = 16'h0000;
        chk("early_wr_cnt", 32'(wr_cnt - base), 32'd3);

        // Missing last
        base = wr_cnt;
        do_start(6'd2);
        drive(16'h0005, 1'b0, 5'd0, "miss0");
        drive(16'h0006, 1'b0, 5'd1, "miss1");
        chk("miss_done", 32'(done), 32'd1);
        chk("miss_err", 32'(err_code), 32'd3);
        chk("miss_csum", 32'(checksum), 32'h000B);
        @(negedge clk);
        chk("miss_wr_cnt", 32'(wr_cnt - base), 32'd2);

        // Bad config: zero words
        base = wr_cnt;
        do_start(6'd0);
        chk("cfg0_done", 32'(done), 32'd1);
        chk("cfg0_err", 32'(err_code), 32'd1);
        chk("cfg0_wen", 32'(wen), 32'd0);
        @(negedge clk);
        chk("cfg0_done_pulse", 32'(done), 32'd0);
        chk("cfg0_busy", 32'(busy), 32'd0);
        chk("cfg0_wen2", 32'(wen), 32'd0);

        // Bad config: one more than the memory depth
        do_start(6'd31);
        chk("cfg31_done", 32'(done), 32'd1);
        chk("cfg31_err", 32'(err_code), 32'd1);
        chk("cfg31_wen", 32'(wen), 32'd0);
        @(negedge clk);
        chk("cfg31_busy", 32'(busy), 32'd0);
        chk("cfg_wr_cnt", 32'(wr_cnt - base), 32'd0);

        // Reset mid-load with an ignored start during LOAD
        base = wr_cnt;
        do_start(6'd10);
        for (int i = 0; i < 4; i++) begin
            drive(16'(16'h0010 + i), 1'b0, 5'(i), $sformatf("rml%0d", i));
        end
        start     = 1'b1;
        cfg_count = 6'd1;
        @(negedge clk);
        start = 1'b0;
        chk("rml_ign_busy", 32'(busy), 32'd1);
        chk("rml_ign_rdy", 32'(s_ready), 32'd1);
        chk("rml_ign_done", 32'(done), 32'd0);
        chk("rml_ign_wen", 32'(wen), 32'd0);
        chk("rml_csum", 32'(checksum), 32'h0046);
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'h0077;
        @(negedge clk);
        chk("rml_rst_wen", 32'(wen), 32'd0);
        chk("rml_rst_busy", 32'(busy), 32'd0);
        chk("rml_rst_rdy", 32'(s_ready), 32'd0);
        chk("rml_rst_csum", 32'(checksum), 32'd0);
        chk("rml_rst_done", 32'(done), 32'd0);
        rst     = 1'b0;
        s_valid = 1'b0;
        s_data  = 16'h0000;
        @(negedge clk);
        chk("rml_wr_cnt", 32'(wr_cnt - base), 32'd4);

        // Follow-up single-word load after reset
        do_start(6'd1);
        drive(16'h1234, 1'b1, 5'd0, "one");
        chk("one_done", 32'(done), 32'd1);
        chk("one_err", 32'(err_code), 32'd0);
        chk("one_csum", 32'(checksum), 32'h1234);
        @(negedge clk);
        chk("one_idle_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
